mem_wb_skid_stage: RTL and testbench

//  MEM->WB pipeline stage with valid/ready handshake and 2-entry skid buffer, so WB backpressure

---
 rtl/mem_wb_skid_stage.sv | 161 ++++++++++++++++
 tb/tb_mem_wb_skid_stage.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB stage: two-entry skid (OUT + SKID), FIFO order, flush kills held entries; latency 1.
// Backpressure: m_ready_o drops only when both entries are held. Build with MEM_WB_LOAD_EXT_EN for load lane extraction.
module mem_wb_skid_stage #(
    parameter int Width   = 32,
    parameter int LdTypeW = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               m_valid_i,
    output logic               m_ready_o,
    input  logic               RegWen_MEM,
    input  logic [1:0]         WBSel_MEM,
    input  logic [LdTypeW-1:0] ld_type_MEM,
    input  logic [Width-1:0]   pc_MEMp4,
    input  logic [Width-1:0]   alu_MEM,
    input  logic [Width-1:0]   dataR,
    input  logic [Width-1:0]   inst_MEM,
    output logic               wb_valid_o,
    input  logic               wb_ready_i,
    output logic               RegWen_WB,
    output logic [1:0]         WBSel_WB,
    output logic [Width-1:0]   pc_WBp4,
    output logic [Width-1:0]   alu_WB,
    output logic [Width-1:0]   mem_WB,
    output logic [Width-1:0]   inst_WB
);

    localparam int OffW = $clog2(Width / 8);

    typedef struct packed {
        logic             regwen;
        logic [1:0]       wbsel;
        logic [Width-1:0] pc;
        logic [Width-1:0] alu;
        logic [Width-1:0] mem;
        logic [Width-1:0] inst;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state_q, state_d;
    entry_t out_q, skid_q, in_e;
    logic   accept, pop;
    logic   load_out, load_skid, out_from_skid;
    logic [Width-1:0] mem_data;

`ifdef MEM_WB_LOAD_EXT_EN
    // Halfword lane ignores off[0]: misaligned halves are not trapped here.
    function automatic logic [Width-1:0] load_ext(
        input logic [LdTypeW-1:0] ld_type,
        input logic [OffW-1:0]    off,
        input logic [Width-1:0]   data
    );
        logic [Width-1:0] sh_b;
        logic [Width-1:0] sh_h;
        logic [OffW-1:0]  off_h;
        logic [7:0]       b;
        logic [15:0]      h;
        off_h = {off[OffW-1:1], 1'b0};
        sh_b  = data >> {off, 3'b000};
        sh_h  = data >> {off_h, 3'b000};
        b     = sh_b[7:0];
        h     = sh_h[15:0];
        case (ld_type)
            LdTypeW'(1): load_ext = {{(Width-8){b[7]}}, b};
            LdTypeW'(2): load_ext = {{(Width-16){h[15]}}, h};
            LdTypeW'(3): load_ext = {{(Width-8){1'b0}}, b};
            LdTypeW'(4): load_ext = {{(Width-16){1'b0}}, h};
            default:     load_ext = data;
        endcase
    endfunction

    assign mem_data = load_ext(ld_type_MEM, alu_MEM[OffW-1:0], dataR);
`else
    // Extension is performed in the WB mux instead; load type is not needed here.
    logic unused_ld_type;
    assign unused_ld_type = ^ld_type_MEM;
    assign mem_data       = dataR;
`endif

    always_comb begin
        in_e        = '0;
        in_e.regwen = RegWen_MEM;
        in_e.wbsel  = WBSel_MEM;
        in_e.pc     = pc_MEMp4;
        in_e.alu    = alu_MEM;
        in_e.mem    = mem_data;
        in_e.inst   = inst_MEM;
    end

    assign m_ready_o  = (state_q != TWO);
    assign wb_valid_o = (state_q != EMPTY);
    assign accept     = m_valid_i & m_ready_o;
    assign pop        = wb_valid_o & wb_ready_i;

    always_comb begin
        state_d       = state_q;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d  = ONE;
                    load_out = 1'b1;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_d   = TWO;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d       = ONE;
                    out_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush wins over any concurrent accept or pop.
        if (flush_i) begin
            state_d       = EMPTY;
            load_out      = 1'b0;
            load_skid     = 1'b0;
            out_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_out) begin
                out_q <= in_e;
            end else if (out_from_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_e;
            end
        end
    end

    assign RegWen_WB = out_q.regwen & wb_valid_o;
    assign WBSel_WB  = out_q.wbsel;
    assign pc_WBp4   = out_q.pc;
    assign alu_WB    = out_q.alu;
    assign mem_WB    = out_q.mem;
    assign inst_WB   = out_q.inst;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Directed bench for mem_wb_skid_stage: reset, streaming, backpressure, flush, load extension.
module tb_mem_wb_skid_stage;

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, m_valid_i, m_ready_o;
    logic        RegWen_MEM;
    logic [1:0]  WBSel_MEM;
    logic [2:0]  ld_type_MEM;
    logic [31:0] pc_MEMp4, alu_MEM, dataR, inst_MEM;
    logic        wb_valid_o, wb_ready_i, RegWen_WB;
    logic [1:0]  WBSel_WB;
    logic [31:0] pc_WBp4, alu_WB, mem_WB, inst_WB;

    int tests = 0;
    int fails = 0;

    mem_wb_skid_stage #(.Width(32), .LdTypeW(3)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .m_valid_i(m_valid_i), .m_ready_o(m_ready_o),
        .RegWen_MEM(RegWen_MEM), .WBSel_MEM(WBSel_MEM), .ld_type_MEM(ld_type_MEM),
        .pc_MEMp4(pc_MEMp4), .alu_MEM(alu_MEM), .dataR(dataR), .inst_MEM(inst_MEM),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .RegWen_WB(RegWen_WB),
        .WBSel_WB(WBSel_WB), .pc_WBp4(pc_WBp4), .alu_WB(alu_WB),
        .mem_WB(mem_WB), .inst_WB(inst_WB)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [2:0]  ext_type [5] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd0};
    logic [31:0] ext_addr [5] = '{32'h102, 32'h103, 32'h102, 32'h101, 32'h100};
`ifdef MEM_WB_LOAD_EXT_EN
    logic [31:0] ext_exp  [5] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF,
                                  32'h0000_7F01, 32'h80FF_7F01};
`else
    logic [31:0] ext_exp  [5] = '{32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01,
                                  32'h80FF_7F01, 32'h80FF_7F01};
`endif

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; m_valid_i = 1'b1; wb_ready_i = 1'b1;
        RegWen_MEM = 1'b1; WBSel_MEM = 2'd2; ld_type_MEM = 3'd0;
        pc_MEMp4 = 32'h44; alu_MEM = 32'd99; dataR = 32'hDEAD_BEEF; inst_MEM = 32'h1234_5678;

        // Reset held two cycles with a valid input present
        tick(); tick();
        check("rst_valid", 32'(wb_valid_o), 32'd0);
        check("rst_regwen", 32'(RegWen_WB), 32'd0);
        check("rst_wbsel", 32'(WBSel_WB), 32'd0);
        check("rst_pc", pc_WBp4, 32'd0);
        check("rst_alu", alu_WB, 32'd0);
        check("rst_mem", mem_WB, 32'd0);
        check("rst_inst", inst_WB, 32'd0);
        rst_i = 1'b0; m_valid_i = 1'b0;
        tick();
        check("post_rst_ready", 32'(m_ready_o), 32'd1);
        check("post_rst_valid", 32'(wb_valid_o), 32'd0);

        // Streaming: four back-to-back accepts with WB always ready
        wb_ready_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            m_valid_i = 1'b1; alu_MEM = 32'(i);
            tick();
            check("stream_valid", 32'(wb_valid_o), 32'd1);
            check("stream_alu", alu_WB, 32'(i));
            check("stream_ready", 32'(m_ready_o), 32'd1);
        end
        check("stream_regwen", 32'(RegWen_WB), 32'd1);
        check("stream_pc", pc_WBp4, 32'h44);
        check("stream_inst", inst_WB, 32'h1234_5678);
        check("stream_wbsel", 32'(WBSel_WB), 32'd2);
        m_valid_i = 1'b0;
        tick();
        check("stream_drain", 32'(wb_valid_o), 32'd0);

        // Backpressure: A, B fill the stage, C must wait
        wb_ready_i = 1'b0;
        m_valid_i = 1'b1; alu_MEM = 32'd10;
        tick();
        check("bp_A_alu", alu_WB, 32'd10);
        check("bp_A_ready", 32'(m_ready_o), 32'd1);
        alu_MEM = 32'd20;
        tick();
        check("bp_B_ready", 32'(m_ready_o), 32'd0);
        check("bp_B_hold", alu_WB, 32'd10);
        alu_MEM = 32'd30;
        tick();
        check("bp_C_held_off", 32'(m_ready_o), 32'd0);
        check("bp_out_stable", alu_WB, 32'd10);
        wb_ready_i = 1'b1;
        tick();
        check("bp_pop_B", alu_WB, 32'd20);
        check("bp_pop_B_ready", 32'(m_ready_o), 32'd1);
        tick();
        check("bp_pop_C", alu_WB, 32'd30);
        m_valid_i = 1'b0;
        tick();
        check("bp_empty", 32'(wb_valid_o), 32'd0);

        // Flush in TWO with a concurrent input
        wb_ready_i = 1'b0;
        m_valid_i = 1'b1; alu_MEM = 32'd40;
        tick();
        alu_MEM = 32'd50;
        tick();
        check("fl_two_ready", 32'(m_ready_o), 32'd0);
        check("fl_two_regwen", 32'(RegWen_WB), 32'd1);
        flush_i = 1'b1; alu_MEM = 32'd60;
        tick();
        flush_i = 1'b0; m_valid_i = 1'b0;
        check("fl_valid", 32'(wb_valid_o), 32'd0);
        check("fl_regwen", 32'(RegWen_WB), 32'd0);
        check("fl_ready", 32'(m_ready_o), 32'd1);
        tick();
        check("fl_no_ghost", 32'(wb_valid_o), 32'd0);

        // Flush beats accept from EMPTY
        flush_i = 1'b1; m_valid_i = 1'b1; alu_MEM = 32'd70;
        tick();
        flush_i = 1'b0; m_valid_i = 1'b0;
        check("fl_beats_accept", 32'(wb_valid_o), 32'd0);
        tick();
        check("fl_beats_accept2", 32'(wb_valid_o), 32'd0);

        // Reset while both entries are held
        m_valid_i = 1'b1; alu_MEM = 32'd80;
        tick();
        alu_MEM = 32'd90;
        tick();
        check("rst_mid_full", 32'(m_ready_o), 32'd0);
        rst_i = 1'b1; m_valid_i = 1'b0;
        tick();
        rst_i = 1'b0;
        check("rst_mid_valid", 32'(wb_valid_o), 32'd0);
        check("rst_mid_alu", alu_WB, 32'd0);
        check("rst_mid_ready", 32'(m_ready_o), 32'd1);
        wb_ready_i = 1'b1;
        tick();
        check("rst_mid_no_skid", 32'(wb_valid_o), 32'd0);

        // Load lane selection / extension
        dataR = 32'h80FF_7F01;
        for (int i = 0; i < 5; i++) begin
            m_valid_i = 1'b1; ld_type_MEM = ext_type[i]; alu_MEM = ext_addr[i];
            tick();
            check("ext_mem", mem_WB, ext_exp[i]);
        end
        m_valid_i = 1'b0;
        tick();
        check("ext_drain", 32'(wb_valid_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
